// File: rtl/freq_counter.sv
// freq_counter: counts rising edges of an asynchronous input over a programmable
// gate window of system-clock cycles and reports the count with a valid pulse.
module freq_counter #(
   parameter int WIDTH       = 8,
   parameter int GATE_SHIFT  = 8,
   parameter int CNT_WIDTH   = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk_in,
   input  logic                 nrst,
   input  logic                 sig_in,
   input  logic                 enable,
   input  logic [WIDTH-1:0]     gate_len,
   output logic [CNT_WIDTH-1:0] count,
   output logic                 valid,
   output logic                 overflow,
   output logic                 busy
);
   localparam int WW = WIDTH + GATE_SHIFT;
   typedef enum logic [1:0] {IDLE, ARM, MEAS, DONE} state_t;
   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   hist_q, hist_d;
   logic [WW-1:0]          win_q, win_d;
   logic [CNT_WIDTH-1:0]   edges_q, edges_d, count_q, count_d;
   logic                   sat_q, sat_d, ovf_q, ovf_d, valid_q, valid_d, busy_q, busy_d;
   logic                   rise, start;
   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], sig_in};
      hist_d  = sync_q[SYNC_STAGES-1];
      rise    = sync_q[SYNC_STAGES-1] & ~hist_q;
      start   = enable && (gate_len != '0);
      state_d = state_q;
      win_d   = win_q;
      edges_d = edges_q;
      sat_d   = sat_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: state_d = start ? ARM : IDLE;
         ARM: begin
            win_d   = {gate_len, {GATE_SHIFT{1'b0}}} - WW'(1);
            edges_d = '0;
            sat_d   = 1'b0;
            state_d = MEAS;
         end
         MEAS: begin
            win_d = win_q - WW'(1);
            if (rise) begin
               if (&edges_q) sat_d = 1'b1;
               else edges_d = edges_q + CNT_WIDTH'(1);
            end
            // abort wins over completion so a dropped enable never reports
            if (!enable) state_d = IDLE;
            else if (win_q == '0) begin
               state_d = DONE;
               count_d = edges_d;
               ovf_d   = sat_d;
            end
         end
         DONE: state_d = start ? ARM : IDLE;
         default: state_d = IDLE;
      endcase
      valid_d = (state_d == DONE);
      busy_d  = (state_d != IDLE);
   end
   always_ff @(posedge clk_in or negedge nrst) begin
      if (!nrst) begin
         state_q <= IDLE;
         sync_q  <= '0;
         hist_q  <= 1'b0;
         win_q   <= '0;
         edges_q <= '0;
         sat_q   <= 1'b0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         hist_q  <= hist_d;
         win_q   <= win_d;
         edges_q <= edges_d;
         sat_q   <= sat_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end
   assign count    = count_q;
   assign valid    = valid_q;
   assign overflow = ovf_q;
   assign busy     = busy_q;
endmodule

// File: doc/freq_counter.md
# freq_counter

Measures the frequency of an asynchronous input clock (the divided clock output or the temperature-sensor ring oscillator) against the system clock. It counts rising edges of `sig_in` during a gate window of programmable length, measured in system-clock cycles. It then presents the count with a one-cycle valid pulse. It is the measuring end paired with the clock divider: the divider produces a scaled clock, and this block recovers its rate.

## Interface
- `WIDTH`, 8: width of `gate_len`.
- `GATE_SHIFT`, 8: gate unit is 2^GATE_SHIFT system-clock cycles.
- `CNT_WIDTH`, 24: width of the edge count result.
- `SYNC_STAGES`, 2: synchronizer depth for `sig_in` (minimum 2).
- `clk_in` input 1: system clock. All logic is in this single domain.
- `nrst` input 1: reset, asynchronous and active-low.
- `sig_in` input 1: asynchronous signal whose rising edges are counted.
- `enable` input 1: level. While high, the block runs back-to-back measurements.
- `gate_len` input WIDTH: gate window = `gate_len` × 2^GATE_SHIFT cycles. A value of 0 disables measurement.
- `count` output CNT_WIDTH: result of the last completed window. Held until the next completion.
- `valid` output 1: one-cycle pulse when `count` updates.
- `overflow` output 1: set with `valid` if the edge count saturated in that window. Held with `count`.
- `busy` output 1: high in ARM, MEASURE and DONE.

## Operation
- Synchronizer: `sig_in` passes through SYNC_STAGES flops, then one history flop. `rise` = synced & ~history.
- Edge counter: CNT_WIDTH bits plus a saturation flag.
  - It increments on `rise` only in MEASURE.
  - It saturates at all-ones and does not wrap. The sat flag is set when an increment is attempted at all-ones.
- Window counter: WIDTH+GATE_SHIFT bits, counting down.
- FSM states are IDLE, ARM, MEASURE and DONE.
  - IDLE: if `enable` && `gate_len`≠0, go to ARM. Otherwise stay.
  - ARM (1 cycle):
    - Load window counter = {`gate_len`, GATE_SHIFT zeros} − 1.
    - Clear the edge counter and sat flag.
    - Go to MEASURE.
  - MEASURE:
    - Decrement the window counter each cycle and count `rise`.
    - At window counter 0, go to DONE. The `rise` in that final cycle is counted.
    - If `enable` falls, abort to IDLE. No `valid` is produced, and `count`/`overflow` are unchanged.
  - DONE (1 cycle):
    - `count` <= edge counter; `overflow` <= sat flag; `valid`=1.
    - If `enable` && `gate_len`≠0, go to ARM. Otherwise go to IDLE.
- `gate_len` is sampled only in ARM. Changes during MEASURE take effect at the next ARM.
- Edges whose `rise` falls in IDLE, ARM or DONE are not counted. This gives 2 cycles of dead time between back-to-back windows.
- Maximum measurable rate is `clk_in`/2. Higher input rates alias; this is not detected.

## Timing
- Reset values: `count`=0, `valid`=0, `overflow`=0, `busy`=0. State is IDLE, and the synchronizer and history flops are 0.
- Reset assertion takes effect immediately at any state, including mid-window. On release, the block starts in IDLE.
- From `enable` sampled high in IDLE: ARM is next cycle, MEASURE the cycle after. MEASURE lasts exactly `gate_len`×2^GATE_SHIFT cycles. `valid` is high in the DONE cycle.
- Back-to-back period = `gate_len`×2^GATE_SHIFT + 2 cycles. `valid` pulses are spaced by exactly this period.
- Input-to-`rise` latency is SYNC_STAGES+1 cycles. Edges within that latency of a window boundary are attributed to the window in which `rise` occurs.
- `busy` is a registered decode of state. It is high from the ARM cycle through the DONE cycle inclusive.

## Test plan
- Default parameters, `gate_len`=1, `sig_in` = `clk_in`/4 with 50% duty, `enable` held high:
  - `valid` pulses every 258 cycles.
  - `count` is 64 every window (63 or 64 if phase-swept); `overflow`=0.
- CNT_WIDTH=4, `gate_len`=1, `sig_in` toggling every `clk_in` cycle:
  - `count`=15 and `overflow`=1 at `valid`.
  - After switching `sig_in` to `clk_in`/32, the next window gives `count`=8 and `overflow`=0.
- `gate_len`=0 with `enable` high for 1000 cycles:
  - `busy` stays 0 and `valid` never pulses.
  - `count` remains at its reset value 0.
- `gate_len`=2, `enable` dropped 100 cycles into MEASURE:
  - Block returns to IDLE the next cycle and `busy`=0.
  - No `valid` is produced; `count` still holds the prior result.
- `gate_len` changed 1→3 mid-window:
  - The current window completes at 256 cycles.
  - The next window lasts 768 cycles, and its count scales ×3 for a fixed-rate `sig_in`.
- `nrst` asserted asynchronously mid-MEASURE (between clock edges):
  - All outputs read 0 before the next `clk_in` edge.
  - After release with `enable` high, the first `valid` arrives at 2 + window cycles.
